// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and the long-latency unit,
// plus a scoreboard of registers awaiting long-latency results for decode hazards.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_addr,
  input  logic [31:0] pipe_wr_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_wr,
  input  logic [4:0]  dec_rd,
  output logic        hazard,
  output logic        wb_stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        pipe_req;
  logic        lu_grant;
  logic        pipe_grant;
  logic [3:0]  starve_cnt;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_eff;

  assign pipe_req = pipe_wr_en && (pipe_wr_addr != '0);

  // Grants are gated by reset so every output is quiet while rst is held low.
  assign lu_grant   = rst && lu_valid && (!pipe_req || (starve_cnt == LIMIT));
  assign pipe_grant = rst && pipe_req && !lu_grant;

  assign lu_ready = lu_grant;
  assign wb_stall = lu_grant && pipe_req;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (lu_grant) begin
      wr_en   = (lu_addr != '0);
      wr_addr = lu_addr;
      wr_data = lu_data;
    end else if (pipe_grant) begin
      wr_en   = 1'b1;
      wr_addr = pipe_wr_addr;
      wr_data = pipe_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (lu_valid && !lu_grant) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask = 32'd1 << iss_rd;
    if (lu_grant)  clr_mask = 32'd1 << lu_addr;
  end

  // Set is applied after clear so a same-cycle issue to a retiring register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
  end

  // The retiring register is forwarded by the register file, so it is not a hazard.
  assign busy_eff = busy & ~clr_mask;

  always_comb begin
    hazard = 1'b0;
    if (rst && dec_valid) begin
      hazard = ((dec_rs1 != '0) && busy_eff[dec_rs1]) ||
               ((dec_rs2 != '0) && busy_eff[dec_rs2]) ||
               (dec_wr && (dec_rd != '0) && busy_eff[dec_rd]);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a sequential vector table applied one row per
// cycle, plus a hand-written asynchronous-reset / starvation-restart sequence.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_wr;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        wb_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_wr(dec_wr), .dec_rd(dec_rd),
    .hazard(hazard), .wb_stall(wb_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pe, pa, pd;
    int unsigned lv, la, ld;
    int unsigned iv, ir;
    int unsigned dv, r1, r2, dw, rd;
    int unsigned x_wen, x_wa, x_wd, x_rdy, x_stall, x_haz, x_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_wr = 1'b0; dec_rd = '0;
  endtask

  // Issuing to a register that is busy and not being retired this cycle is illegal.
  always @(posedge clk) begin
    if (rst && iss_valid && iss_rd != 5'd0 && busy[iss_rd] &&
        !(lu_ready && lu_addr == iss_rd)) begin
      bad++;
      $display("FAIL waw_issue: issue to busy register %0d", iss_rd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pe pa pd            lv la ld       iv ir  dv r1 r2 dw rd  wen wa wd           rdy st hz busy
    tbl.push_back('{1, 5, 'hDEADBEEF, 0, 0, 0,       0, 0,  0, 0, 0, 0, 0,  1, 5, 'hDEADBEEF, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 'h1234,     0, 0, 0,       0, 0,  0, 0, 0, 0, 0,  0, 0, 0,          0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,          1, 4, 'hA5A5,  0, 0,  0, 0, 0, 0, 0,  1, 4, 'hA5A5,     1, 0, 0, 0});
    tbl.push_back('{0, 0, 0,          1, 0, 'h55,    0, 0,  0, 0, 0, 0, 0,  0, 0, 'h55,       1, 0, 0, 0});
    tbl.push_back('{1, 2, 'h22,       1, 7, 'h77,    0, 0,  0, 0, 0, 0, 0,  1, 2, 'h22,       0, 0, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 7, 'h77,    0, 0,  0, 0, 0, 0, 0,  1, 3, 'h33,       0, 0, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 7, 'h77,    0, 0,  0, 0, 0, 0, 0,  1, 3, 'h33,       0, 0, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 7, 'h77,    0, 0,  0, 0, 0, 0, 0,  1, 3, 'h33,       0, 0, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 7, 'h77,    0, 0,  0, 0, 0, 0, 0,  1, 7, 'h77,       1, 1, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 8, 'h88,    0, 0,  0, 0, 0, 0, 0,  1, 3, 'h33,       0, 0, 0, 0});
    tbl.push_back('{1, 3, 'h33,       1, 8, 'h88,    0, 0,  0, 0, 0, 0, 0,  1, 3, 'h33,       0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,          1, 8, 'h88,    1, 9,  0, 0, 0, 0, 0,  1, 8, 'h88,       1, 0, 0, 0});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       1, 0,  1, 0, 9, 0, 0,  0, 0, 0,          0, 0, 1, 'h200});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       0, 0,  1, 0, 9, 0, 0,  0, 0, 0,          0, 0, 1, 'h200});
    tbl.push_back('{0, 0, 0,          1, 9, 'h99,    1, 12, 1, 0, 9, 0, 0,  1, 9, 'h99,       1, 0, 0, 'h200});
    tbl.push_back('{0, 0, 0,          1, 12, 'hC,    1, 12, 1, 9, 0, 0, 0,  1, 12, 'hC,       1, 0, 0, 'h1000});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       1, 3,  1, 0, 0, 1, 12, 0, 0, 0,          0, 0, 1, 'h1000});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       0, 0,  1, 0, 0, 1, 3,  0, 0, 0,          0, 0, 1, 'h1008});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       0, 0,  0, 0, 0, 1, 3,  0, 0, 0,          0, 0, 0, 'h1008});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       0, 0,  1, 0, 0, 0, 3,  0, 0, 0,          0, 0, 0, 'h1008});
    tbl.push_back('{0, 0, 0,          1, 3, 'h3C,    0, 0,  1, 12, 0, 0, 0, 1, 3, 'h3C,       1, 0, 1, 'h1008});
    tbl.push_back('{0, 0, 0,          1, 12, 'h0,    0, 0,  1, 12, 0, 0, 0, 1, 12, 0,         1, 0, 0, 'h1000});
    tbl.push_back('{0, 0, 0,          0, 0, 0,       0, 0,  0, 0, 0, 0, 0,  0, 0, 0,          0, 0, 0, 0});

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy",   busy, 32'h0);
    chk("rst_wr_en",  32'(wr_en), 32'h0);
    chk("rst_hazard", 32'(hazard), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      pipe_wr_en = tbl[i].pe[0]; pipe_wr_addr = 5'(tbl[i].pa); pipe_wr_data = tbl[i].pd;
      lu_valid = tbl[i].lv[0]; lu_addr = 5'(tbl[i].la); lu_data = tbl[i].ld;
      iss_valid = tbl[i].iv[0]; iss_rd = 5'(tbl[i].ir);
      dec_valid = tbl[i].dv[0]; dec_rs1 = 5'(tbl[i].r1); dec_rs2 = 5'(tbl[i].r2);
      dec_wr = tbl[i].dw[0]; dec_rd = 5'(tbl[i].rd);
      #2;
      chk($sformatf("v%0d_wr_en", i),    32'(wr_en),    tbl[i].x_wen);
      chk($sformatf("v%0d_wr_addr", i),  32'(wr_addr),  tbl[i].x_wa);
      chk($sformatf("v%0d_wr_data", i),  wr_data,       tbl[i].x_wd);
      chk($sformatf("v%0d_lu_ready", i), 32'(lu_ready), tbl[i].x_rdy);
      chk($sformatf("v%0d_wb_stall", i), 32'(wb_stall), tbl[i].x_stall);
      chk($sformatf("v%0d_hazard", i),   32'(hazard),   tbl[i].x_haz);
      chk($sformatf("v%0d_busy", i),     busy,          tbl[i].x_busy);
    end

    // Build busy=0x210 and starve_cnt=3, then reset asynchronously mid-cycle.
    @(negedge clk); idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd4;
    @(negedge clk); iss_rd = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd2; pipe_wr_data = 32'h2;
      lu_valid = 1'b1; lu_addr = 5'd1; lu_data = 32'h1111;
    end
    @(negedge clk);
    dec_valid = 1'b1; dec_rs1 = 5'd4;
    #2;
    chk("pre_rst_busy",   busy, 32'h0000_0210);
    chk("pre_rst_hazard", 32'(hazard), 32'h1);
    chk("pre_rst_ready",  32'(lu_ready), 32'h0);
    chk("pre_rst_wr_en",  32'(wr_en), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_busy",     busy, 32'h0);
    chk("async_wr_en",    32'(wr_en), 32'h0);
    chk("async_lu_ready", 32'(lu_ready), 32'h0);
    chk("async_wb_stall", 32'(wb_stall), 32'h0);
    chk("async_hazard",   32'(hazard), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Starvation count must restart from zero after reset: 4 losses, then a win.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk($sformatf("post_rst_ready%0d", k), 32'(lu_ready), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("post_rst_stall%0d", k), 32'(wb_stall), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("post_rst_waddr%0d", k), 32'(wr_addr),  (k == 4) ? 32'h1 : 32'h2);
      chk($sformatf("post_rst_haz%0d", k),   32'(hazard),   32'h0);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("final_busy", busy, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the integer register file. It shares the single register-file write port between two sources: the in-order pipeline writeback and the long-latency unit result port (mul/div/load-miss). It also tracks which registers still have long-latency results outstanding, and flags RAW/WAW hazards to decode. It sits between the WB stage, the long-latency unit and the `wr_en/wr_addr/wr_data` inputs of the register file.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a valid long-latency result may lose arbitration before the pipeline is stalled in its favour (1..15).
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pipe_wr_en  input  1  pipeline WB write request.
- pipe_wr_addr  input  5  pipeline destination register.
- pipe_wr_data  input  32  pipeline write data.
- lu_valid  input  1  long-latency result valid.
- lu_ready  output  1  long-latency result accepted this cycle.
- lu_addr  input  5  long-latency destination register.
- lu_data  input  32  long-latency result data.
- iss_valid  input  1  long-latency op issued this cycle.
- iss_rd  input  5  its destination register.
- dec_valid  input  1  decode stage holds a valid instruction.
- dec_rs1, dec_rs2  input  5 each  decode source registers.
- dec_wr  input  1  decode instruction writes a register.
- dec_rd  input  5  decode destination register.
- hazard  output  1  decode must stall.
- wb_stall  output  1  WB stage must hold; the pipeline re-presents the same request next cycle.
- wr_en  output  1  register-file write enable.
- wr_addr  output  5  register-file write address.
- wr_data  output  32  register-file write data.
- busy  output  32  scoreboard bits (bit 0 always 0).

## Operation
- Effective requests:
  - pipe_req = pipe_wr_en && pipe_wr_addr != 0.
  - lu_req = lu_valid. An lu_addr of 0 is still handshaken but never written.
- Grant, combinational each cycle:
  - LU wins if lu_req && (!pipe_req || starve_cnt == STARVE_LIMIT). Then lu_ready=1 and wb_stall=pipe_req.
  - Otherwise pipe wins if pipe_req. Then lu_ready=0 and wb_stall=0.
  - Otherwise there is no write.
- Write port outputs:
  - wr_en = (LU granted && lu_addr != 0) || (pipe granted).
  - wr_addr and wr_data come from the granted source.
  - wr_addr and wr_data are 0 when no source is granted.
- starve_cnt, 4-bit register:
  - Reset value 0.
  - Increments, saturating at STARVE_LIMIT, when lu_valid && !lu_ready.
  - Clears to 0 when lu_valid && lu_ready, and whenever !lu_valid.
- Scoreboard busy[31:1], registered:
  - Set at the clock edge when iss_valid && iss_rd != 0.
  - Cleared at the clock edge when an LU handshake targets that register.
  - If set and clear hit the same register in the same cycle, set wins.
  - Issuing to an already-busy register is illegal (decode's WAW check prevents it); the bench asserts it never occurs. The bit simply stays set.
- hazard = dec_valid && any of the following:
  - (dec_rs1 != 0 && busy_eff[dec_rs1])
  - (dec_rs2 != 0 && busy_eff[dec_rs2])
  - (dec_wr && dec_rd != 0 && busy_eff[dec_rd])
  - Here busy_eff = busy with the bit currently being cleared by an LU handshake masked off. The register file forwards same-cycle write data, so no stall is needed for that register.
  - A same-cycle iss_valid does not affect hazard until the next cycle.

## Timing
- Grant, write-port outputs, lu_ready, wb_stall and hazard are combinational from the inputs and registered state: zero latency.
- The register-file write lands at the next rising edge.
- Scoreboard and starve_cnt update on the rising edge.
- LU handshake: lu_valid must stay asserted with stable lu_addr/lu_data until lu_ready. The result is consumed in the cycle where both are high.
- Worst-case LU wait under continuous pipe traffic is STARVE_LIMIT cycles; LU is granted in the following cycle.
- Reset (rst low), asynchronous:
  - busy=0 and starve_cnt=0 immediately.
  - wr_en, lu_ready, wb_stall and hazard are forced to 0 while reset is held.
  - Reset mid-handshake drops the in-flight LU result; the LU must re-present it after reset.
- Back-to-back LU results are accepted every cycle when pipe_req=0.

## Test plan
- Pipe only: pipe_wr_en=1, addr=5, data=0xDEADBEEF -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wb_stall=0. With addr=0 -> wr_en=0.
- Contention: pipe_req held every cycle, lu_valid=1 for addr 7 -> lu_ready=0 for 4 cycles (starve_cnt 1..4), then in the 5th cycle lu_ready=1, wr_addr=7, wb_stall=1; starve_cnt=0 afterwards.
- Scoreboard RAW: iss_valid with iss_rd=9; next cycle dec_valid with dec_rs2=9 -> hazard=1 until the cycle of the LU handshake on addr 9. In that cycle hazard=0 and wr_addr=9; busy[9]=0 afterwards.
- Set/clear same cycle: LU handshake on addr 12 while iss_valid iss_rd=12 -> busy[12]=1 after the edge. Also iss_rd=0 -> busy unchanged, busy[0]=0.
- WAW: busy[3]=1, dec_wr=1, dec_rd=3, rs1=rs2=0 -> hazard=1. With dec_valid=0 -> hazard=0.
- Reset mid-operation: busy=0x00000210, starve_cnt=3, lu_valid=1; pull rst low -> busy=0, starve_cnt=0, wr_en=lu_ready=wb_stall=hazard=0 without waiting for a clock edge.
